// File: rtl/usb_crc16_core.sv
// USB data-packet CRC16 generator: folds one byte per clock into a reflected
// 0xA001 shift register, bit 0 of each byte first.
module usb_crc16_core (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  data_in,
    input  logic        crc_en,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Eight LSB-first shift/XOR steps unrolled into one combinational byte update.
    function automatic logic [15:0] crcByte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] r;
        r = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (r[0]) begin
                r = (r >> 1) ^ 16'hA001;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (crc_en) begin
            crc_d = crcByte(crc_q, data_in);
        end
    end

    // Reset preloads all ones; there is no synchronous clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: tb/tb_usb_crc16_core.sv
// Directed self-checking bench for usb_crc16_core using known CRC16/USB vectors.
module tb_usb_crc16_core;

    logic        clk;
    logic        n_rst;
    logic [7:0]  data_in;
    logic        crc_en;
    logic [15:0] crc_out;

    int vectors;
    int miscompares;

    usb_crc16_core dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .data_in (data_in),
        .crc_en  (crc_en),
        .crc_out (crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic feedByte(input logic [7:0] b);
        crc_en  = 1'b1;
        data_in = b;
        @(posedge clk);
        #1;
        crc_en  = 1'b0;
    endtask

    task automatic idle(input int n);
        crc_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_in = 8'(i * 37 + 5);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        crc_en = 1'b0;
        data_in = 8'h00;
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic feedCheckString();
        for (int i = 0; i < 9; i++) begin
            feedByte(8'h31 + 8'(i));
        end
    endtask

    task automatic test_reset();
        crc_en  = 1'b0;
        data_in = 8'hA5;
        #2;
        n_rst = 1'b0;
        #1;
        vectors++;
        if (crc_out !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL reset_value: got %h expected ffff", crc_out);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = (i == 2) ? 8'hxx : ((i % 2 == 0) ? 8'h5A : 8'hC3);
            @(posedge clk);
            #1;
            vectors++;
            if (crc_out !== 16'hFFFF) begin
                miscompares++;
                $display("[TB] FAIL idle_hold_%0d: got %h expected ffff", i, crc_out);
            end
        end
    endtask

    task automatic test_single_zero();
        doReset();
        feedByte(8'h00);
        vectors++;
        if (crc_out !== 16'h40BF) begin
            miscompares++;
            $display("[TB] FAIL single_zero: got %h expected 40bf", crc_out);
        end
        idle(2);
        vectors++;
        if (crc_out !== 16'h40BF) begin
            miscompares++;
            $display("[TB] FAIL single_zero_hold: got %h expected 40bf", crc_out);
        end
    endtask

    task automatic test_check_string();
        doReset();
        feedCheckString();
        vectors++;
        if (crc_out !== 16'h4B37) begin
            miscompares++;
            $display("[TB] FAIL check_string: got %h expected 4b37", crc_out);
        end
    endtask

    task automatic test_residue();
        feedByte(8'h37);
        feedByte(8'h4B);
        vectors++;
        if (crc_out !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL residue: got %h expected 0000", crc_out);
        end
    endtask

    task automatic test_gaps();
        doReset();
        for (int i = 0; i < 4; i++) begin
            feedByte(8'h31 + 8'(i));
            idle(3);
        end
        for (int i = 4; i < 9; i++) begin
            feedByte(8'h31 + 8'(i));
        end
        vectors++;
        if (crc_out !== 16'h4B37) begin
            miscompares++;
            $display("[TB] FAIL gaps: got %h expected 4b37", crc_out);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        crc_en  = 1'b1;
        data_in = 8'h00;
        @(posedge clk);
        #1;
        vectors++;
        if (crc_out !== 16'h40BF) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_first: got %h expected 40bf", crc_out);
        end
        @(posedge clk);
        #1;
        crc_en = 1'b0;
        vectors++;
        if (crc_out !== 16'hB001) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_second: got %h expected b001", crc_out);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        for (int i = 0; i < 4; i++) begin
            feedByte(8'h31 + 8'(i));
        end
        crc_en  = 1'b1;
        data_in = 8'h35;
        #2;
        n_rst = 1'b0;
        #1;
        vectors++;
        if (crc_out !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL async_reset_immediate: got %h expected ffff", crc_out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (crc_out !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL async_reset_held: got %h expected ffff", crc_out);
        end
        crc_en = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (crc_out !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL async_reset_release: got %h expected ffff", crc_out);
        end
        feedCheckString();
        vectors++;
        if (crc_out !== 16'h4B37) begin
            miscompares++;
            $display("[TB] FAIL async_reset_refeed: got %h expected 4b37", crc_out);
        end
    endtask

    task automatic test_first_edge_after_reset();
        crc_en  = 1'b0;
        n_rst   = 1'b0;
        @(posedge clk);
        crc_en  = 1'b1;
        data_in = 8'h00;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        crc_en = 1'b0;
        vectors++;
        if (crc_out !== 16'h40BF) begin
            miscompares++;
            $display("[TB] FAIL first_edge_absorb: got %h expected 40bf", crc_out);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_rst       = 1'b1;
        crc_en      = 1'b0;
        data_in     = 8'h00;
        test_reset();
        test_single_zero();
        test_check_string();
        test_residue();
        test_gaps();
        test_back_to_back();
        test_async_reset();
        test_first_edge_after_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
